// File: rtl/game_pkg.sv
// Shared types and constants for the battleship defender side.
package game_pkg;
  typedef enum logic [1:0] {EMPTY = 2'b00, SHIP = 2'b01, MISS = 2'b10, HIT = 2'b11} cell_t;
  typedef enum logic [1:0] {ANS_NONE = 2'b00, ANS_MISS = 2'b01, ANS_HIT = 2'b10, ANS_INVALID = 2'b11} answer_t;

  localparam int GRID_SIZE = 10;
  localparam int ROW_HI = 7;
  localparam int ROW_LO = 4;
  localparam int COL_HI = 3;
  localparam int COL_LO = 0;

  function automatic logic pos_in_range(input logic [7:0] pos, input int grid);
    return (int'(pos[ROW_HI:ROW_LO]) < grid) && (int'(pos[COL_HI:COL_LO]) < grid);
  endfunction
endpackage

// File: rtl/board_regfile.sv
// GRID x GRID board of 2-bit cells: one write port with all-clear, lookup and renderer read ports.
module board_regfile
  import game_pkg::*;
#(
  parameter int GRID = GRID_SIZE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_clr,
  input  logic       i_we,
  input  logic [7:0] i_wpos,
  input  logic [1:0] i_wdata,
  input  logic [7:0] i_lk_pos,
  output logic [1:0] o_lk_cell,
  input  logic [7:0] i_rd_pos,
  output logic [1:0] o_rd_cell
);
  logic [GRID-1:0][GRID-1:0][1:0] r_cells;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_cells <= '0;
    else if (i_clr)
      r_cells <= '0;
    else if (i_we && pos_in_range(i_wpos, GRID))
      r_cells[i_wpos[ROW_HI:ROW_LO]][i_wpos[COL_HI:COL_LO]] <= i_wdata;
  end

  // Out-of-range addresses read as EMPTY so callers never index past the array.
  assign o_lk_cell = pos_in_range(i_lk_pos, GRID) ?
                     r_cells[i_lk_pos[ROW_HI:ROW_LO]][i_lk_pos[COL_HI:COL_LO]] : EMPTY;
  assign o_rd_cell = pos_in_range(i_rd_pos, GRID) ?
                     r_cells[i_rd_pos[ROW_HI:ROW_LO]][i_rd_pos[COL_HI:COL_LO]] : EMPTY;
endmodule

// File: rtl/shot_responder.sv
// Defender: places fleet, answers opponent shots over valid/ready, tracks ships left and loss.
// Define SHOT_REPEAT_CHECK_EN to answer repeated shots (MISS/HIT cells) as invalid.
module shot_responder
  import game_pkg::*;
#(
  parameter int GRID = GRID_SIZE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       new_game,
  input  logic       place_we,
  input  logic [7:0] place_pos,
  input  logic       arm,
  input  logic       shot_valid,
  input  logic [7:0] shot_pos,
  output logic       shot_ready,
  output logic       ans_valid,
  output logic [1:0] ans_code,
  input  logic       ans_ready,
  output logic [6:0] ships_left,
  output logic       game_lost,
  input  logic [7:0] rd_pos,
  output logic [1:0] rd_cell
);
  typedef enum logic [1:0] {IDLE, LOOKUP, RESPOND} state_t;

  state_t     r_state, w_next;
  logic       r_armed, r_game_lost;
  logic [7:0] r_shot_pos;
  logic [1:0] r_ans_code;
  logic [6:0] r_ships_left;

  logic       w_shot_ready, w_accept, w_lookup, w_place, w_shot_wr, w_dec, w_we;
  logic [1:0] w_lk_cell, w_code, w_shot_data, w_wdata;
  logic [7:0] w_lk_pos;

  // Placement and shots never overlap (armed splits them), so one lookup port serves both.
  assign w_lk_pos = r_armed ? r_shot_pos : place_pos;
  assign w_lookup = (r_state == LOOKUP);
  assign w_place  = place_we & ~r_armed & pos_in_range(place_pos, GRID) & (w_lk_cell == EMPTY);
  assign w_accept = shot_valid & w_shot_ready;
  assign w_we     = (w_lookup & w_shot_wr) | w_place;
  assign w_wdata  = r_armed ? w_shot_data : SHIP;

  board_regfile #(.GRID(GRID)) u_board (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (new_game),
    .i_we      (w_we),
    .i_wpos    (w_lk_pos),
    .i_wdata   (w_wdata),
    .i_lk_pos  (w_lk_pos),
    .o_lk_cell (w_lk_cell),
    .i_rd_pos  (rd_pos),
    .o_rd_cell (rd_cell)
  );

  always_comb begin
    w_code      = ANS_INVALID;
    w_shot_wr   = 1'b0;
    w_shot_data = SHIP;
    w_dec       = 1'b0;
    if (pos_in_range(r_shot_pos, GRID)) begin
      case (cell_t'(w_lk_cell))
        EMPTY: begin w_code = ANS_MISS; w_shot_wr = 1'b1; w_shot_data = MISS; end
        SHIP:  begin w_code = ANS_HIT;  w_shot_wr = 1'b1; w_shot_data = HIT; w_dec = 1'b1; end
`ifdef SHOT_REPEAT_CHECK_EN
        default: w_code = ANS_INVALID;
`else
        MISS:    w_code = ANS_MISS;
        default: w_code = ANS_HIT;
`endif
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    w_shot_ready = 1'b0;
    case (r_state)
      IDLE: begin
        w_shot_ready = r_armed & ~r_game_lost;
        if (shot_valid && w_shot_ready) w_next = LOOKUP;
      end
      LOOKUP:  w_next = RESPOND;
      RESPOND: if (ans_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
    if (new_game) w_next = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_armed      <= 1'b0;
      r_shot_pos   <= '0;
      r_ans_code   <= ANS_NONE;
      r_ships_left <= '0;
      r_game_lost  <= 1'b0;
    end else if (new_game) begin
      r_armed      <= 1'b0;
      r_ans_code   <= ANS_NONE;
      r_ships_left <= '0;
      r_game_lost  <= 1'b0;
    end else begin
      if (arm)      r_armed    <= 1'b1;
      if (w_accept) r_shot_pos <= shot_pos;
      if (w_lookup) r_ans_code <= w_code;
      if (w_place)
        r_ships_left <= r_ships_left + 7'd1;
      else if (w_lookup && w_dec)
        r_ships_left <= r_ships_left - 7'd1;
      // Covers both the final hit and arming an empty fleet.
      if (r_armed && ((r_ships_left == 7'd0) || (w_lookup && w_dec && r_ships_left == 7'd1)))
        r_game_lost <= 1'b1;
    end
  end

  assign shot_ready = w_shot_ready;
  assign ans_valid  = (r_state == RESPOND);
  assign ans_code   = r_ans_code;
  assign ships_left = r_ships_left;
  assign game_lost  = r_game_lost;
endmodule

// File: tb/tb_shot_responder.sv
// Directed bench for shot_responder with a board-level reference model checked every cycle.
module tb_shot_responder;
  logic       clk = 1'b0, rst = 1'b1, new_game = 1'b0, place_we = 1'b0, arm = 1'b0;
  logic       shot_valid = 1'b0, ans_ready = 1'b0;
  logic [7:0] place_pos = '0, shot_pos = '0, rd_pos = '0;
  logic       shot_ready, ans_valid, game_lost;
  logic [1:0] ans_code, rd_cell;
  logic [6:0] ships_left;

`ifdef SHOT_REPEAT_CHECK_EN
  localparam bit REPEAT_CHK = 1'b1;
`else
  localparam bit REPEAT_CHK = 1'b0;
`endif
  localparam int G = 10;

  // model: cell values 0 empty, 1 ship, 2 miss, 3 hit
  int mb [16][16];
  int m_ships = 0, m_code = 0;
  bit m_armed = 0, m_lost = 0, m_busy = 0, m_resp = 0;
  bit chk_en = 0;
  int tot_m = 0, bad_m = 0, tot_c = 0, bad_c = 0;
  logic [7:0] sweep [8] = '{8'h23, 8'h24, 8'h55, 8'hA0, 8'h00, 8'h99, 8'h77, 8'h11};
  int sw_i = 0;
  int code;

  shot_responder #(.GRID(G)) dut (
    .clk(clk), .rst(rst), .new_game(new_game), .place_we(place_we), .place_pos(place_pos),
    .arm(arm), .shot_valid(shot_valid), .shot_pos(shot_pos), .shot_ready(shot_ready),
    .ans_valid(ans_valid), .ans_code(ans_code), .ans_ready(ans_ready),
    .ships_left(ships_left), .game_lost(game_lost), .rd_pos(rd_pos), .rd_cell(rd_cell)
  );

  always #5 clk = ~clk;

  function automatic int model_rd(input logic [7:0] p);
    int r = int'(p[7:4]);
    int c = int'(p[3:0]);
    return (r < G && c < G) ? mb[r][c] : 0;
  endfunction

  function automatic int model_shot(input logic [7:0] p);
    int r = int'(p[7:4]);
    int c = int'(p[3:0]);
    if (r >= G || c >= G) return 3;
    case (mb[r][c])
      0: begin mb[r][c] = 2; return 1; end
      1: begin
        mb[r][c] = 3;
        m_ships--;
        if (m_ships == 0) m_lost = 1;
        return 2;
      end
      2:       return REPEAT_CHK ? 3 : 1;
      default: return REPEAT_CHK ? 3 : 2;
    endcase
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++) mb[i][j] = 0;
    m_ships = 0; m_lost = 0; m_armed = 0; m_busy = 0; m_resp = 0; m_code = 0;
  endtask

  task automatic cchk(input string nm, input int act, input int exp);
    tot_c++;
    if (act != exp) begin
      bad_c++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic lchk(input string nm, input int act, input int exp);
    tot_m++;
    if (act != exp) begin
      bad_m++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cchk("cmp ships_left", int'(ships_left), m_ships);
      cchk("cmp game_lost", int'(game_lost), int'(m_lost));
      cchk("cmp shot_ready", int'(shot_ready), int'(m_armed && !m_lost && !m_busy));
      cchk("cmp ans_valid", int'(ans_valid), int'(m_resp));
      if (m_resp) cchk("cmp ans_code", int'(ans_code), m_code);
      cchk("cmp rd_cell", int'(rd_cell), model_rd(rd_pos));
    end
  end

  task automatic tick();
    @(posedge clk); #1;
    rd_pos = sweep[sw_i];
    sw_i = (sw_i + 1) % 8;
  endtask

  task automatic rd_chk(input string nm, input logic [7:0] p, input int exp);
    rd_pos = p; #1;
    lchk(nm, int'(rd_cell), exp);
  endtask

  task automatic place(input logic [7:0] p);
    int r = int'(p[7:4]);
    int c = int'(p[3:0]);
    place_we = 1'b1; place_pos = p;
    tick();
    place_we = 1'b0;
    if (!m_armed && r < G && c < G && mb[r][c] == 0) begin
      mb[r][c] = 1;
      m_ships++;
    end
  endtask

  task automatic arm_game();
    arm = 1'b1;
    tick();
    m_armed = 1;
    if (m_ships == 0) begin
      tick();
      m_lost = 1;
    end
  endtask

  task automatic do_new_game();
    new_game = 1'b1; arm = 1'b0; ans_ready = 1'b0;
    tick();
    new_game = 1'b0;
    model_clear();
  endtask

  task automatic start_shot(input logic [7:0] p, output int c);
    int n = 0;
    c = -1;
    while (!shot_ready && n < 20) begin tick(); n++; end
    if (!shot_ready) begin
      lchk("shot_ready wait timeout", 0, 1);
      return;
    end
    ans_ready = 1'b0; shot_valid = 1'b1; shot_pos = p;
    tick();
    shot_valid = 1'b0; m_busy = 1;
    lchk("lookup ans_valid", int'(ans_valid), 0);
    tick();
    m_code = model_shot(p); m_resp = 1; c = m_code;
    lchk("respond ans_valid", int'(ans_valid), 1);
  endtask

  task automatic finish_shot(input int hold);
    ans_ready = 1'b0;
    repeat (hold) tick();
    ans_ready = 1'b1;
    tick();
    ans_ready = 1'b0; m_busy = 0; m_resp = 0;
  endtask

  task automatic shot(input string nm, input logic [7:0] p, input int exp);
    int c;
    start_shot(p, c);
    lchk(nm, int'(ans_code), exp);
    finish_shot(0);
  endtask

  initial begin
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    lchk("rst shot_ready", int'(shot_ready), 0);
    lchk("rst ans_valid", int'(ans_valid), 0);
    lchk("rst ans_code", int'(ans_code), 0);
    lchk("rst ships_left", int'(ships_left), 0);
    lchk("rst game_lost", int'(game_lost), 0);
    rd_chk("rst rd_cell", 8'h23, 0);
    rst = 1'b0; chk_en = 1;

    place(8'h23); place(8'h24); place(8'h23); place(8'hA5); place(8'h5A);
    lchk("ships after place", int'(ships_left), 2);
    rd_chk("placed 24", 8'h24, 1);
    arm_game();
    lchk("armed shot_ready", int'(shot_ready), 1);
    place(8'h50);
    lchk("place while armed", int'(ships_left), 2);

    shot("shot 23 hit", 8'h23, 2);
    lchk("ships after hit", int'(ships_left), 1);
    rd_chk("rd 23 hit", 8'h23, 3);
    shot("shot 55 miss", 8'h55, 1);
    rd_chk("rd 55 miss", 8'h55, 2);
    shot("shot A0 row oob", 8'hA0, 3);
    shot("shot 0A col oob", 8'h0A, 3);
    rd_chk("rd A0 oob", 8'hA0, 0);
    shot("repeat 23", 8'h23, REPEAT_CHK ? 3 : 2);
    lchk("ships after repeat", int'(ships_left), 1);
    shot("repeat 55", 8'h55, REPEAT_CHK ? 3 : 1);

    start_shot(8'h77, code);
    repeat (20) tick();
    lchk("backpressure ans_code", int'(ans_code), 1);
    lchk("backpressure shot_ready", int'(shot_ready), 0);
    finish_shot(0);

    shot("shot 24 last", 8'h24, 2);
    lchk("ships at end", int'(ships_left), 0);
    lchk("lost at end", int'(game_lost), 1);
    lchk("ready when lost", int'(shot_ready), 0);

    do_new_game();
    place(8'h11);
    arm_game();
    start_shot(8'h11, code);
    lchk("lost before new_game", int'(game_lost), 1);
    do_new_game();
    lchk("new_game ans_valid", int'(ans_valid), 0);
    lchk("new_game game_lost", int'(game_lost), 0);
    lchk("new_game ships", int'(ships_left), 0);
    rd_chk("new_game rd 11", 8'h11, 0);
    rd_chk("new_game rd 55", 8'h55, 0);

    arm_game();
    lchk("arm empty lost", int'(game_lost), 1);
    lchk("arm empty ready", int'(shot_ready), 0);
    do_new_game();

    place(8'h11); place(8'h33);
    arm_game();
    shot("shot 33 pre-rst", 8'h33, 2);
    shot_valid = 1'b1; shot_pos = 8'h11;
    tick();
    shot_valid = 1'b0;
    chk_en = 0;
    rst = 1'b1; #1;
    lchk("midrst shot_ready", int'(shot_ready), 0);
    lchk("midrst ans_valid", int'(ans_valid), 0);
    lchk("midrst ans_code", int'(ans_code), 0);
    lchk("midrst ships", int'(ships_left), 0);
    lchk("midrst game_lost", int'(game_lost), 0);
    rd_chk("midrst rd 33", 8'h33, 0);
    arm = 1'b0;
    model_clear();
    tick();
    rst = 1'b0; chk_en = 1;
    repeat (3) tick();
    lchk("post-rst ready", int'(shot_ready), 0);

    $display("test done: total=%0d bad=%0d", tot_m + tot_c, bad_m + bad_c);
    $finish;
  end
endmodule

// File: doc/shot_responder.md
# shot_responder

Defender side of the shot exchange in the battleship game. Stores the local player's fleet on a 10×10 board and accepts the opponent's shot coordinate from the link. It looks the coordinate up, marks the cell, and returns a coded answer to the shooter through a valid/ready handshake. It also tracks the remaining ship cells and flags a lost game; the renderer reads cell state through a read port.

## Interface
Parameters:
- GRID, 10, board edge length; rows and columns run 0..GRID-1.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- new_game  in  1  synchronous one-cycle clear of board, counters and `game_lost`.
- place_we  in  1  write a ship cell during placement.
- place_pos  in  8  placement coordinate; [7:4] row, [3:0] column.
- arm  in  1  level; high ends placement and enables shots.
- shot_valid  in  1  incoming shot present.
- shot_pos  in  8  shot coordinate; [7:4] row, [3:0] column.
- shot_ready  out  1  responder can accept a shot.
- ans_valid  out  1  answer present.
- ans_code  out  2  01 miss, 10 hit, 11 invalid/repeat, 00 never driven while `ans_valid` is high.
- ans_ready  in  1  shooter consumed the answer.
- ships_left  out  7  remaining un-hit ship cells.
- game_lost  out  1  sticky; all ship cells hit.
- rd_pos  in  8  renderer read coordinate.
- rd_cell  out  2  cell state at `rd_pos`, combinational from board registers.

## Operation
- Cell states: EMPTY 00, SHIP 01, MISS 10, HIT 11.
- FSM states: IDLE, LOOKUP, RESPOND.
- IDLE:
  - `shot_ready` = `armed` & !`game_lost`.
  - On `shot_valid` & `shot_ready`, latch `shot_pos` and go to LOOKUP.
- LOOKUP (one cycle): classify the latched cell, update the board, then go to RESPOND.
  - Out-of-range coordinate (row or column ≥ GRID) -> code 11, no board change.
  - SHIP -> code 10; cell becomes HIT; `ships_left` decrements.
  - EMPTY -> code 01; cell becomes MISS.
  - MISS or HIT: see Configuration.
- RESPOND: `ans_valid` = 1 and `ans_code` is held stable; on `ans_ready`, return to IDLE.
- Placement:
  - `place_we` while `armed` = 0 and coordinate in range on an EMPTY cell -> cell becomes SHIP; `ships_left` increments.
  - On a SHIP cell or out of range, the write is ignored.
- `armed` is set when `arm` is high and cleared only by `rst` or `new_game`. `place_we` is ignored while armed.
- `game_lost` is set in the same cycle the decrement brings `ships_left` to 0, while armed.
- Arming with `ships_left` = 0 sets `game_lost` on the next cycle.
- `rd_pos` out of range returns EMPTY.

## Timing
- Reset values:
  - Board all EMPTY, FSM in IDLE.
  - `shot_ready` = 0, `ans_valid` = 0, `ans_code` = 00, `ships_left` = 0, `game_lost` = 0, `armed` = 0.
- Latency:
  - Handshake in cycle N; LOOKUP in N+1; `ans_valid` high from N+2.
  - The board update is visible on `rd_cell` from N+2.
  - Minimum shot-to-shot spacing is 3 cycles, with `ans_ready` held high.
- `shot_ready` is low in LOOKUP and RESPOND; no shot is lost while busy, because the sender holds `shot_valid` until it sees `shot_ready`.
- `ans_valid` and `ans_code` stay stable until `ans_ready`; backpressure of any length is allowed.
- `new_game` takes priority over every other input in its cycle and returns the FSM to IDLE. Any pending answer is dropped.
- `rst` mid-operation returns to the reset values immediately.
- `place_we` and a shot in the same cycle cannot both take effect: placement requires `armed` = 0 and shots require `armed` = 1.

## Configuration
- `SHOT_REPEAT_CHECK_EN` defined: a shot on a MISS or HIT cell answers 11, with no board change and no counter change.
- Undefined:
  - A shot on a MISS cell answers 01.
  - A shot on a HIT cell answers 10, with no decrement.
  - Board unchanged in both cases.

## Structure
- Shared package `game_pkg`:
  - `cell_t` enum (EMPTY, SHIP, MISS, HIT).
  - `answer_t` codes (ANS_NONE 00, ANS_MISS 01, ANS_HIT 10, ANS_INVALID 11).
  - `GRID_SIZE` = 10.
  - Coordinate nibble layout constants.
- Sub-module `board_regfile`:
  - GRID×GRID×2-bit register array.
  - One synchronous write port with an all-clear input.
  - Two combinational read ports: lookup and renderer.

## Test plan
- Place SHIP at 0x23 and 0x24, then arm: `ships_left` = 2, `shot_ready` = 1.
- Shot 0x23 accepted in cycle N, `ans_ready` = 1 -> `ans_valid` in N+2, code 10, `ships_left` = 1, `rd_cell`(0x23) = 11.
- Shot 0x55 -> code 01, `rd_cell`(0x55) = 10. Shot 0xA0 (row 10) -> code 11, board unchanged.
- Repeat shot 0x23:
  - With `SHOT_REPEAT_CHECK_EN` -> code 11.
  - Without -> code 10.
  - `ships_left` stays 1 in both cases.
- Hold `ans_ready` = 0 for 20 cycles -> `ans_code` stable and `shot_ready` = 0. Then shot 0x24 completes -> `ships_left` = 0, `game_lost` = 1, `shot_ready` = 0.
- Assert `new_game` while in RESPOND -> `ans_valid` = 0, all cells EMPTY and `game_lost` = 0 next cycle. Assert `rst` in LOOKUP -> all outputs return to their reset values.
